obf_key_loader: RTL and testbench
=================================

OBF_KEY_LOADER -- requirements
Module: obf_key_loader

Interface
REQ-001 Parameter KEY_W, default 12: key width; 2 bits per obfuscated site (6 sites).
REQ-002 Parameter MAX_TRIES, default 3: failed load attempts allowed before permanent lockout.
REQ-003 Parameter SAFE_KEY, default all ones: value driven on key_o until a key is committed (every site forced to constant 0).
REQ-004 clk  input  1  single clock; all state on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  one-cycle pulse that opens a load frame.
REQ-007 bit_i  input  1  serial key data.
REQ-008 valid_i  input  1  bit_i is valid this cycle.
REQ-009 ready_o  output  1  the loader accepts bit_i this cycle.
REQ-010 key_o  output  KEY_W  key vector to the obfuscated core; bit k drives core key input D_k.
REQ-011 locked_o  output  1  a valid key is committed.
REQ-012 err_o  output  1  the last frame failed parity.
REQ-013 dead_o  output  1  permanent lockout.

Function
REQ-014 Site encoding, m = {D_2k+1, D_2k}: 00 pass, 01 force 1, 10 invert, 11 force 0; the loader stores the bits and does not interpret them.
REQ-015 Frame format: KEY_W key bits, D_0 first, followed by 1 parity bit.
  - Parity makes the total number of ones in the KEY_W+1 bits even.
REQ-016 States: IDLE, SHIFT, CHECK, LOCKED, FAIL, DEAD.
REQ-017 IDLE or FAIL + start_i -> SHIFT.
  - Bit counter cleared; shift register cleared; err_o cleared.
REQ-018 SHIFT behaviour:
  - ready_o = 1.
  - A bit transfers only when valid_i && ready_o; its value goes to position count.
  - Count increments by 1 per transfer.
  - The transfer at count = KEY_W captures the parity bit -> CHECK next cycle.
REQ-019 SHIFT + valid_i low holds all state; there is no timeout.
REQ-020 start_i during SHIFT restarts the frame with the same action as REQ-017.
  - The try counter is not incremented.
REQ-021 CHECK lasts exactly one cycle, ready_o = 0.
REQ-022 CHECK, parity good -> LOCKED.
  - key_o <= shift register; locked_o = 1.
  - key_o changes exactly one cycle after the parity bit handshake.
REQ-023 CHECK, parity bad -> try counter increments.
  - Counter < MAX_TRIES -> FAIL with err_o = 1.
  - Counter = MAX_TRIES -> DEAD.
REQ-024 LOCKED and DEAD are terminal until reset.
  - start_i and valid_i are ignored; ready_o = 0.
REQ-025 key_o equals SAFE_KEY in every state except LOCKED.
  - A partially shifted key never appears on key_o.
REQ-026 DEAD: dead_o = 1, err_o = 1, key_o = SAFE_KEY.
REQ-027 ready_o is a registered state decode; no combinational path from any input to any output.
REQ-028 valid_i outside SHIFT is ignored and the bit is dropped.

Reset
REQ-029 rst_n low, asynchronously:
  - state = IDLE; counters = 0; shift register = 0.
  - key_o = SAFE_KEY; ready_o, locked_o, err_o, dead_o = 0.
REQ-030 Reset mid-frame or in LOCKED/DEAD discards all progress, including the try counter.
REQ-031 Release is synchronised by the integrator; the block does not synchronise the release itself.

Structure
REQ-032 Shared package obf_key_pkg holds:
  - KEY_W default.
  - Site-mode enum (PASS, FORCE1, INVERT, FORCE0) with the REQ-014 codes.
  - State enum.
  - SAFE_KEY constant.
REQ-033 One sub-module, obf_key_shreg: KEY_W-bit indexed capture register with running parity; the FSM stays in obf_key_loader.

Verification
REQ-034 Reset, then start_i, 12 bits of key 12'h000 (all sites pass), parity 0:
  - One cycle after the parity handshake: key_o = 12'h000, locked_o = 1, ready_o = 0.
REQ-035 Key 12'b010110_011001 with parity bit 0 (six ones, even):
  - key_o = 12'b010110_011001.
  - A frame sent afterwards leaves it unchanged.
REQ-036 Key 12'h001 with parity 0:
  - err_o = 1, key_o = 12'hFFF.
  - A retry with parity 1 locks with key_o = 12'h001.
REQ-037 Three consecutive bad-parity frames:
  - dead_o = 1 and ready_o = 0 after the third CHECK.
  - A following good frame is ignored.
REQ-038 valid_i toggled randomly during a frame, plus start_i pulsed after bit 5:
  - Only the bits after the restart are committed.
  - key_o stays 12'hFFF until CHECK.
REQ-039 rst_n asserted at bit 7 and again while LOCKED:
  - key_o = 12'hFFF within the same cycle.
  - All flags = 0; try counter cleared.

Source files
------------

// File: rtl/obf_key_pkg.sv
// rtl/obf_key_pkg.sv - shared types and constants for the obfuscation key loader
package obf_key_pkg;

    localparam int KEY_W_DEF = 12;

    // Value held on the key bus until a key is committed: every site forced to 0
    localparam logic [KEY_W_DEF-1:0] SAFE_KEY_DEF = {KEY_W_DEF{1'b1}};

    // Two key bits per obfuscated site, {D_2k+1, D_2k}; the loader never decodes these
    typedef enum logic [1:0] {
        SITE_PASS   = 2'b00,
        SITE_FORCE1 = 2'b01,
        SITE_INVERT = 2'b10,
        SITE_FORCE0 = 2'b11
    } site_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4,
        ST_DEAD   = 3'd5
    } state_e;

endpackage

// File: rtl/obf_key_shreg.sv
// rtl/obf_key_shreg.sv - indexed key capture register with running parity
module obf_key_shreg #(
    parameter int KEY_W = 12,
    parameter int CW    = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [CW-1:0]    idx_i,
    input  logic             bit_i,
    output logic [KEY_W-1:0] data_o,
    output logic             par_o
);

    logic [KEY_W-1:0] data_q, data_d;
    logic             par_q, par_d;

    // Place the incoming bit at its index; the parity bit (index KEY_W) only feeds parity
    always_comb begin
        data_d = data_q;
        par_d  = par_q;
        if (clear_i) begin
            data_d = '0;
            par_d  = 1'b0;
        end else if (we_i) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (idx_i == CW'(i)) begin
                    data_d[i] = bit_i;
                end
            end
            par_d = par_q ^ bit_i;
        end
    end

    // Capture register and running parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            par_q  <= par_d;
        end
    end

    assign data_o = data_q;
    assign par_o  = par_q;

endmodule

// File: rtl/obf_key_loader.sv
// rtl/obf_key_loader.sv - serial key loader with parity check, retry limit and lockout
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int               KEY_W     = KEY_W_DEF,
    parameter int               MAX_TRIES = 3,
    parameter logic [KEY_W-1:0] SAFE_KEY  = {KEY_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             bit_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             dead_o
);

    localparam int CW = $clog2(KEY_W + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [TW-1:0]    tries_inc;
    logic [KEY_W-1:0] key_q, key_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             sh_clear, sh_we;
    logic [KEY_W-1:0] sh_data;
    logic             sh_par;

    assign tries_inc = tries_q + 1'b1;

    obf_key_shreg #(
        .KEY_W (KEY_W),
        .CW    (CW)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (sh_clear),
        .we_i    (sh_we),
        .idx_i   (cnt_q),
        .bit_i   (bit_i),
        .data_o  (sh_data),
        .par_o   (sh_par)
    );

    // Next-state logic: frame sequencing, parity verdict and retry accounting
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        key_d    = key_q;
        err_d    = err_q;
        sh_clear = 1'b0;
        sh_we    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start_i) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = '0;
                    sh_clear = 1'b1;
                    err_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (start_i) begin
                    // Restart drops the partial frame without costing a try
                    cnt_d    = '0;
                    sh_clear = 1'b1;
                    err_d    = 1'b0;
                end else if (valid_i) begin
                    sh_we = 1'b1;
                    if (cnt_q == CW'(KEY_W)) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (!sh_par) begin
                    state_d = ST_LOCKED;
                    key_d   = sh_data;
                end else begin
                    tries_d = tries_inc;
                    err_d   = 1'b1;
                    state_d = (tries_inc >= TW'(MAX_TRIES)) ? ST_DEAD : ST_FAIL;
                end
            end
            ST_LOCKED, ST_DEAD: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_SHIFT);
    end

    // State and output registers; key bus returns to the safe value asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tries_q <= '0;
            key_q   <= SAFE_KEY;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            key_q   <= key_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o  = ready_q;
    assign key_o    = key_q;
    assign err_o    = err_q;
    assign locked_o = (state_q == ST_LOCKED);
    assign dead_o   = (state_q == ST_DEAD);

endmodule

// File: tb/tb_obf_key_loader.sv
// tb/tb_obf_key_loader.sv - directed self-checking bench for obf_key_loader
module tb_obf_key_loader;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        bit_i;
    logic        valid_i;
    logic        ready_o;
    logic [11:0] key_o;
    logic        locked_o;
    logic        err_o;
    logic        dead_o;

    int n_checks = 0;
    int n_fail   = 0;

    obf_key_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .bit_i    (bit_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .key_o    (key_o),
        .locked_o (locked_o),
        .err_o    (err_o),
        .dead_o   (dead_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [11:0] k, input logic rdy,
                             input logic lck, input logic er, input logic dd);
        chk({tag, ".key"},    32'(key_o),    32'(k));
        chk({tag, ".ready"},  32'(ready_o),  32'(rdy));
        chk({tag, ".locked"}, 32'(locked_o), 32'(lck));
        chk({tag, ".err"},    32'(err_o),    32'(er));
        chk({tag, ".dead"},   32'(dead_o),   32'(dd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        bit_i   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Sends v[0..n-1] LSB first, with up to gap_max idle (valid low, random data) cycles before each bit
    task automatic send_bits(input logic [12:0] v, input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                for (int j = 0; j < g; j++) begin
                    valid_i = 1'b0;
                    bit_i   = 1'($urandom);
                    @(negedge clk);
                end
            end
            valid_i = 1'b1;
            bit_i   = v[i];
            @(negedge clk);
        end
        valid_i = 1'b0;
        bit_i   = 1'b0;
    endtask

    // Ends at the negedge of the CHECK cycle
    task automatic send_frame(input logic [11:0] k, input logic par, input int gap_max);
        pulse_start();
        send_bits({par, k}, 13, gap_max);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        valid_i = 1'b0;
        bit_i   = 1'b0;
        repeat (2) @(negedge clk);
        chk_flags("reset", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // All-pass key
        send_frame(12'h000, 1'b0, 0);
        chk_flags("zero.check", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_flags("zero.lock", 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Mixed key, then a later frame must be ignored
        do_reset();
        send_frame(12'b010110_011001, 1'b0, 0);
        @(negedge clk);
        chk_flags("mixed.lock", 12'h599, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(12'h0AA, 1'b0, 0);
        @(negedge clk);
        chk_flags("mixed.hold", 12'h599, 1'b0, 1'b1, 1'b0, 1'b0);

        // Bad parity then retry
        do_reset();
        send_frame(12'h001, 1'b0, 0);
        @(negedge clk);
        chk_flags("bad1.fail", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        chk_flags("retry.start", 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits({1'b1, 12'h001}, 13, 0);
        @(negedge clk);
        chk_flags("retry.lock", 12'h001, 1'b0, 1'b1, 1'b0, 1'b0);

        // Three failures lead to permanent lockout
        do_reset();
        send_frame(12'h003, 1'b1, 0);
        @(negedge clk);
        chk_flags("try1", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(12'h003, 1'b1, 0);
        @(negedge clk);
        chk_flags("try2", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(12'h003, 1'b1, 0);
        @(negedge clk);
        chk_flags("try3.dead", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(12'h000, 1'b0, 0);
        @(negedge clk);
        chk_flags("dead.ignore", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1);

        // Gappy valid with a restart after six junk bits
        do_reset();
        pulse_start();
        send_bits(13'h1FFF, 6, 2);
        chk_flags("gap.partial", 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(12'h5A3, 1'b0, 3);
        chk_flags("gap.check", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_flags("gap.lock", 12'h5A3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame and while locked
        do_reset();
        pulse_start();
        send_bits(13'h0055, 7, 0);
        #2 rst_n = 1'b0;
        #1 chk_flags("rst.midframe", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(12'h0F0, 1'b0, 0);
        @(negedge clk);
        chk_flags("rst.prelock", 12'h0F0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_flags("rst.locked", 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Try counter must restart from zero after reset
        send_frame(12'h001, 1'b0, 0);
        send_frame(12'h001, 1'b0, 0);
        @(negedge clk);
        do_reset();
        send_frame(12'h001, 1'b0, 0);
        @(negedge clk);
        send_frame(12'h001, 1'b0, 0);
        @(negedge clk);
        chk_flags("tries.cleared", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(12'h001, 1'b0, 0);
        @(negedge clk);
        chk_flags("tries.dead", 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
